mem_wb_master: RTL and testbench

Wishbone initiator bridge. It converts a native valid/ready memory request (CPU-style valid, address, write data, byte strobes) into classic single-beat Wishbone master cycles. It sits between a core or user-side sequencer and Wishbone responders such as the logic-analyzer register block. A bus timeout guarantees that every request completes, even when the responder never answers.

---
 rtl/mem_wb_master.sv | 152 +++++++++++++++
 tb/tb_mem_wb_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_master.sv
// Wishbone initiator bridge: turns a valid/ready memory request into one classic
// single-beat Wishbone cycle, with a bus timeout so every request completes.
module mem_wb_master #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_error,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;

    logic timeout_hit;
    logic bus_end;
    logic bus_fail;

    // Response decode in BUS: err beats ack, ack beats the timeout.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (cnt_q == TIMEOUT_CYCLES - 16'd1);
        bus_end     = wbm_err_i | wbm_ack_i | timeout_hit;
        bus_fail    = wbm_err_i | (~wbm_ack_i & timeout_hit);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mem_valid) state_d = StBus;
            StBus:  if (bus_end) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the timeout counter.
    always_comb begin
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    adr_d = mem_addr;
                    dat_d = mem_wdata;
                    we_d  = |mem_wstrb;
                    sel_d = (|mem_wstrb) ? mem_wstrb : 4'hF;
                    cyc_d = 1'b1;
                    cnt_d = 16'd0;
                end
            end
            StBus: begin
                if (bus_end) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    error_d = bus_fail;
                    // Writes leave the read-data register untouched.
                    if (!we_q) begin
                        rdata_d = bus_fail ? ERR_RDATA : wbm_dat_i;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                ready_d = 1'b0;
                error_d = 1'b0;
            end
            default: begin
                cyc_d = 1'b0;
            end
        endcase
    end

    // Output and counter registers; reset abandons any cycle in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= 16'd0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_error = error_q;

endmodule

// File: tb/tb_mem_wb_master.sv
// Directed bench for mem_wb_master with an 8-cycle bus timeout.
module tb_mem_wb_master;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    int checks   = 0;
    int failures = 0;

    mem_wb_master #(
        .TIMEOUT_CYCLES(16'd8),
        .ERR_RDATA     (32'hFFFF_FFFF)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_error(mem_error),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_we_o (wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge (accepted when the DUT is idle).
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        step();
        mem_valid = 1'b0;
        mem_addr  = 32'hDEAD_BEEF;
        mem_wdata = 32'h0BAD_F00D;
        mem_wstrb = 4'h3;
    endtask

    initial begin
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        wbm_dat_i = 32'd0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        step();
        step();
        check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        resetn = 1'b1;
        step();

        // Full-word write, three wait states then ack.
        issue(32'h2200_0004, 32'hA5A5_1234, 4'hF);
        for (int i = 0; i < 4; i++) begin
            check("wr_cyc", {31'd0, wbm_cyc_o}, 32'd1);
            check("wr_stb", {31'd0, wbm_stb_o}, 32'd1);
            check("wr_adr", wbm_adr_o, 32'h2200_0004);
            check("wr_dat", wbm_dat_o, 32'hA5A5_1234);
            check("wr_sel", {28'd0, wbm_sel_o}, 32'hF);
            check("wr_we", {31'd0, wbm_we_o}, 32'd1);
            check("wr_wait_ready", {31'd0, mem_ready}, 32'd0);
            if (i == 3) wbm_ack_i = 1'b1;
            step();
        end
        wbm_ack_i = 1'b0;
        check("wr_end_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("wr_end_ready", {31'd0, mem_ready}, 32'd1);
        check("wr_end_error", {31'd0, mem_error}, 32'd0);
        check("wr_end_rdata", mem_rdata, 32'd0);
        step();
        check("wr_done_ready", {31'd0, mem_ready}, 32'd0);

        // Zero-wait read.
        issue(32'h2200_0010, 32'd0, 4'h0);
        check("rd_sel", {28'd0, wbm_sel_o}, 32'hF);
        check("rd_we", {31'd0, wbm_we_o}, 32'd0);
        check("rd_adr", wbm_adr_o, 32'h2200_0010);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_0000;
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        check("rd_ready", {31'd0, mem_ready}, 32'd1);
        check("rd_rdata", mem_rdata, 32'hFFFF_0000);
        check("rd_error", {31'd0, mem_error}, 32'd0);
        step();
        check("rd_done_ready", {31'd0, mem_ready}, 32'd0);

        // Late ack while idle is ignored.
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        check("late_ack_ready", {31'd0, mem_ready}, 32'd0);

        // Byte-lane write.
        issue(32'h2200_0020, 32'h00AB_0000, 4'b0100);
        check("bw_sel", {28'd0, wbm_sel_o}, 32'h4);
        check("bw_we", {31'd0, wbm_we_o}, 32'd1);
        check("bw_dat", wbm_dat_o, 32'h00AB_0000);
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        check("bw_ready", {31'd0, mem_ready}, 32'd1);
        check("bw_error", {31'd0, mem_error}, 32'd0);
        check("bw_rdata_kept", mem_rdata, 32'hFFFF_0000);
        step();

        // Read with err and ack together: err wins.
        issue(32'h2200_0030, 32'd0, 4'h0);
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'h1111_1111;
        step();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        check("err_ready", {31'd0, mem_ready}, 32'd1);
        check("err_error", {31'd0, mem_error}, 32'd1);
        check("err_rdata", mem_rdata, 32'hFFFF_FFFF);
        step();
        check("err_done_ready", {31'd0, mem_ready}, 32'd0);
        check("err_done_error", {31'd0, mem_error}, 32'd0);

        // Timeout: cyc high for exactly 8 cycles.
        issue(32'h2200_0040, 32'd0, 4'h0);
        for (int i = 0; i < 7; i++) begin
            check("to_cyc", {31'd0, wbm_cyc_o}, 32'd1);
            check("to_ready", {31'd0, mem_ready}, 32'd0);
            step();
        end
        check("to_cyc_last", {31'd0, wbm_cyc_o}, 32'd1);
        step();
        check("to_end_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("to_end_ready", {31'd0, mem_ready}, 32'd1);
        check("to_end_error", {31'd0, mem_error}, 32'd1);
        check("to_end_rdata", mem_rdata, 32'hFFFF_FFFF);
        step();

        // Ack on the timeout edge: ack wins.
        issue(32'h2200_0044, 32'd0, 4'h0);
        for (int i = 0; i < 7; i++) step();
        check("toack_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        check("toack_ready", {31'd0, mem_ready}, 32'd1);
        check("toack_error", {31'd0, mem_error}, 32'd0);
        check("toack_rdata", mem_rdata, 32'h1234_5678);
        step();

        // Reset in BUS with an ack pending abandons the cycle.
        issue(32'h2200_0050, 32'h5555_AAAA, 4'hF);
        check("rb_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        resetn    = 1'b0;
        wbm_ack_i = 1'b1;
        step();
        check("rb_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
        check("rb_stb_low", {31'd0, wbm_stb_o}, 32'd0);
        check("rb_ready", {31'd0, mem_ready}, 32'd0);
        check("rb_adr", wbm_adr_o, 32'd0);
        resetn = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        check("rb_after_ready", {31'd0, mem_ready}, 32'd0);
        issue(32'h2200_0060, 32'd0, 4'h0);
        check("rb_new_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0000_CAFE;
        step();
        wbm_ack_i = 1'b0;
        check("rb_new_ready", {31'd0, mem_ready}, 32'd1);
        check("rb_new_rdata", mem_rdata, 32'h0000_CAFE);
        step();

        // mem_valid held across two requests: one request per 3 cycles.
        mem_valid = 1'b1;
        mem_addr  = 32'h2200_0070;
        mem_wstrb = 4'h0;
        step();
        check("b2b_first_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h7777_0001;
        step();
        wbm_ack_i = 1'b0;
        check("b2b_first_ready", {31'd0, mem_ready}, 32'd1);
        check("b2b_done_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        mem_addr = 32'h2200_0074;
        step();
        // Valid is ignored in DONE; this is the single IDLE-state cycle.
        check("b2b_idle_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("b2b_idle_ready", {31'd0, mem_ready}, 32'd0);
        step();
        mem_valid = 1'b0;
        check("b2b_second_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        check("b2b_second_adr", wbm_adr_o, 32'h2200_0074);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h7777_0002;
        step();
        wbm_ack_i = 1'b0;
        check("b2b_second_ready", {31'd0, mem_ready}, 32'd1);
        check("b2b_second_rdata", mem_rdata, 32'h7777_0002);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
